multiplexor_secuencial: RTL

Parametrised, registered N-channel data multiplexer: next generation of the team's 4-channel selector, generalised in data width and channel count, with a registered output, a valid flag and an automatic round-robin scan mode that sweeps all channels with a programmable dwell time. Sits between parallel sensor/data sources and a single downstream consumer (display driver, serial transmitter).

---
 rtl/multiplexor_secuencial.sv | 106 ++++++++++
 1 files changed

// File: rtl/multiplexor_secuencial.sv
// multiplexor_secuencial: registered N-channel mux with manual select and optional round-robin scan.
// Scan mode (BARRIDO state, dwell counter, o_Fin) is compiled in only when MULTIPLEXOR_BARRIDO_EN is defined.
module multiplexor_secuencial #(
    parameter int ANCHO        = 4,
    parameter int CANALES      = 4,
    parameter int PERMANENCIA  = 4,
    localparam int SEL_W       = $clog2(CANALES)
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_n,
    input  logic [CANALES*ANCHO-1:0]   i_Datos,
    input  logic [SEL_W-1:0]           i_Sel,
    input  logic                       i_Modo,
    input  logic                       i_Habilita,
    output logic [ANCHO-1:0]           o_Salida,
    output logic [SEL_W-1:0]           o_Canal,
    output logic                       o_Valido,
    output logic                       o_Fin
);
    logic [ANCHO-1:0] salida_q, salida_d;
    logic [SEL_W-1:0] canal_q, canal_d, sel_c;
    logic             valido_q, valido_d;

    // Out-of-range selects only exist for non-power-of-2 channel counts
    assign sel_c = (int'(i_Sel) > CANALES - 1) ? SEL_W'(CANALES - 1) : i_Sel;

`ifdef MULTIPLEXOR_BARRIDO_EN
    localparam int CNT_W = (PERMANENCIA > 1) ? $clog2(PERMANENCIA) : 1;
    typedef enum logic {MANUAL, BARRIDO} estado_t;
    estado_t          estado_q, estado_d;
    logic [SEL_W-1:0] idx_q, idx_d, idx_cur;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
    logic             fin_q, fin_d, ultimo;

    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        salida_d = salida_q;
        canal_d  = canal_q;
        valido_d = 1'b0;
        fin_d    = 1'b0;
        // The entry cycle behaves as a scan cycle starting from channel 0
        idx_cur  = (estado_q == BARRIDO) ? idx_q : '0;
        cnt_cur  = (estado_q == BARRIDO) ? cnt_q : '0;
        ultimo   = cnt_cur == CNT_W'(PERMANENCIA - 1);
        if (i_Habilita) begin
            valido_d = 1'b1;
            estado_d = i_Modo ? BARRIDO : MANUAL;
            canal_d  = i_Modo ? idx_cur : sel_c;
            salida_d = i_Datos[int'(canal_d)*ANCHO +: ANCHO];
            cnt_d    = ultimo ? '0 : cnt_cur + 1'b1;
            idx_d    = !ultimo ? idx_cur : (idx_cur == SEL_W'(CANALES - 1)) ? '0 : idx_cur + 1'b1;
            fin_d    = i_Modo && ultimo && (idx_cur == SEL_W'(CANALES - 1));
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            estado_q <= MANUAL;
            idx_q    <= '0;
            cnt_q    <= '0;
            fin_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            fin_q    <= fin_d;
        end
    end

    assign o_Fin = fin_q;
`else
    logic unused_modo;

    always_comb begin
        salida_d = salida_q;
        canal_d  = canal_q;
        valido_d = 1'b0;
        if (i_Habilita) begin
            valido_d = 1'b1;
            canal_d  = sel_c;
            salida_d = i_Datos[int'(sel_c)*ANCHO +: ANCHO];
        end
    end

    assign unused_modo = i_Modo;
    assign o_Fin       = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            salida_q <= '0;
            canal_q  <= '0;
            valido_q <= 1'b0;
        end else begin
            salida_q <= salida_d;
            canal_q  <= canal_d;
            valido_q <= valido_d;
        end
    end

    assign o_Salida = salida_q;
    assign o_Canal  = canal_q;
    assign o_Valido = valido_q;
endmodule
